loop_uhat_sparse_udiv_75ns_4ns_71_seq_1: RTL



---
 rtl/loop_uhat_sparse_udiv_75ns_4ns_71_seq_1.sv | 139 +++++++++++++
 1 files changed

// File: rtl/loop_uhat_sparse_udiv_75ns_4ns_71_seq_1.sv
// Iterative restoring unsigned divider, one quotient bit per enabled cycle.
// Optional registered status output enabled by LOOP_UHAT_SPARSE_UDIV_STATUS_EN.
module loop_uhat_sparse_udiv_75ns_4ns_71_seq_1 #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 77,
  parameter int din0_WIDTH = 75,
  parameter int din1_WIDTH = 4,
  parameter int dout_WIDTH = 71
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] remd,
`ifdef LOOP_UHAT_SPARSE_UDIV_STATUS_EN
  output logic [1:0]            status,
`endif
  output logic [1:0]            state_dbg
);

  localparam int N  = din0_WIDTH;
  localparam int D  = din1_WIDTH;
  localparam int OW = dout_WIDTH;
  localparam int CW = $clog2(N + 1);

  // Handshake: start is accepted on an enabled edge while ready is high;
  // done is high for exactly one enabled cycle (stretched while ce is low).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [D-1:0]  div_q, div_d;
  logic [D:0]    rem_q, rem_d;
  logic [OW-1:0] dout_q, dout_d;
  logic [D-1:0]  remd_q, remd_d;
  logic [D+1:0]  r_w;
  logic          q_bit;
`ifdef LOOP_UHAT_SPARSE_UDIV_STATUS_EN
  logic [1:0]    status_q, status_d;
  logic          ovf_w;

  // Overflow looks at the quotient bits that dout cannot carry.
  if (OW < N) begin : g_ovf
    assign ovf_w = |dvd_q[N-2:OW-1];
  end else begin : g_no_ovf
    assign ovf_w = 1'b0;
  end
`endif

  // The dividend register shifts out its MSB and shifts in quotient bits,
  // so after N steps it holds the full quotient.
  assign r_w   = {rem_q, dvd_q[N-1]};
  assign q_bit = (r_w >= {2'b00, div_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    div_d    = div_q;
    rem_d    = rem_q;
    dout_d   = dout_q;
    remd_d   = remd_q;
`ifdef LOOP_UHAT_SPARSE_UDIV_STATUS_EN
    status_d = status_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = din0;
          div_d   = din1;
          rem_d   = '0;
          cnt_d   = CW'(N);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        dvd_d = {dvd_q[N-2:0], q_bit};
        rem_d = q_bit ? (D+1)'(r_w - {2'b00, div_q}) : r_w[D:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          dout_d   = {dvd_q[OW-2:0], q_bit};
          remd_d   = rem_d[D-1:0];
`ifdef LOOP_UHAT_SPARSE_UDIV_STATUS_EN
          status_d = {ovf_w, (div_q == '0)};
`endif
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      dout_q   <= '0;
      remd_q   <= '0;
`ifdef LOOP_UHAT_SPARSE_UDIV_STATUS_EN
      status_q <= '0;
`endif
    end else if (ce) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      dout_q   <= dout_d;
      remd_q   <= remd_d;
`ifdef LOOP_UHAT_SPARSE_UDIV_STATUS_EN
      status_q <= status_d;
`endif
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dout      = dout_q;
  assign remd      = remd_q;
  assign state_dbg = state_q;
`ifdef LOOP_UHAT_SPARSE_UDIV_STATUS_EN
  assign status    = status_q;
`endif

endmodule
